imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Upstream of the single-cycle CPU. Receives the program as a byte stream over a valid/ready handshake.
//  Assembles little-endian 32-bit words and writes them into instruction memory at consecutive word addresses.
//  Holds the CPU stopped (cpu_run=0) until the terminator word 32'h00000033 has been written.
//  Reports overflow if instruction memory fills before the terminator arrives.
// PARAMETERS
//  DEPTH   32              instruction memory depth in words
//  ADDR_W  $clog2(DEPTH)   word-address width
// PORTS
//  clk         in   1         system clock, all state on rising edge
//  reset_n     in   1         asynchronous active-low reset
//  restart     in   1         sync pulse: abandon current load/program, reload from word 0
//  in_valid    in   1         in_data holds a valid byte
//  in_data     in   8         program byte, little-endian order within each word
//  in_ready    out  1         loader accepts a byte this cycle
//  wr_en       out  1         instruction memory write strobe (single cycle)
//  wr_addr     out  ADDR_W    word address for write (byte address = wr_addr<<2)
//  wr_data     out  32        assembled instruction word
//  cpu_run     out  1         1 = program loaded, CPU may execute; 0 = hold CPU
//  load_done   out  1         1-cycle pulse when the terminator word is written
//  overflow    out  1         sticky: DEPTH words written without a terminator
//  word_count  out  ADDR_W+1  number of words written since reset/restart
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - state=LOAD, byte_idx=0, word_count=0, shift reg=0.
//    - Outputs: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_run=0, load_done=0, overflow=0.
//  - Byte accepted iff in_valid & in_ready.
//    - Byte k (k=0..3) goes to wr_data[8k+7:8k]; byte_idx wraps 3->0.
//  - States:
//    - LOAD: in_ready=1. On acceptance of byte 3 -> WRITE.
//    - WRITE: in_ready=0 for exactly one cycle.
//      - wr_en=1, wr_addr=word_count[ADDR_W-1:0], wr_data=assembled word; word_count++ at the cycle end.
//      - Next state:
//        - word==32'h00000033 -> DONE, with load_done=1 in the same WRITE cycle.
//        - else word_count+1==DEPTH -> ERROR.
//        - else -> LOAD.
//    - DONE: in_ready=0, cpu_run=1 (registered, asserted from the first DONE cycle), holds until restart/reset.
//    - ERROR: in_ready=0, overflow=1, cpu_run=0, holds until restart/reset.
//  - Throughput: 4 bytes per 5 cycles max; in_valid may deassert between bytes, partial word retained.
//  - The terminator word is itself written to memory; it is the CPU stop instruction.
//  - restart=1 in any state, including simultaneously with a byte handshake:
//    - The byte is dropped (in_ready is forced to 0 that cycle) and any WRITE in progress is suppressed (wr_en=0).
//    - Next cycle: LOAD, byte_idx=0, word_count=0, cpu_run=0, overflow=0.
//  - Reset mid-load discards the partial word; memory contents are not cleared (not this block's job).
//  - wr_addr/wr_data hold their last values when wr_en=0.
//  - word_count never exceeds DEPTH.
// TESTING
//  1. Stream 33 00 00 00 after reset:
//     - one wr_en, addr 0, data 32'h00000033; load_done pulse in the same cycle; cpu_run=1 on the next cycle.
//  2. Stream 8 bytes: 03 A2 04 00 | 33 00 00 00
//     - writes 32'h0004A203 @0, then 32'h00000033 @1; word_count=2; cpu_run=1.
//  3. Random in_valid gaps (idle 0-3 cycles between bytes), 3-word program:
//     - same writes as gap-free; in_ready=0 exactly in WRITE cycles.
//  4. DEPTH=32 words of 32'h00000013 with no terminator:
//     - 32 writes at addr 0..31; then overflow=1, cpu_run=0, in_ready=0.
//  5. restart asserted together with byte 2 of word 1:
//     - no write; next cycle word_count=0, in_ready=1; reload writes from addr 0.
//  6. reset_n pulsed low mid-word, asynchronously between clock edges:
//     - outputs go to reset values immediately; the subsequent word lands at addr 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module  : imem_loader_if
// Purpose : Byte-stream and instruction-memory write bus for imem_loader
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    // master: byte source and memory sink; slave: the loader itself
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Purpose : Assembles a little-endian byte stream into words, writes them to
//           instruction memory and releases the CPU after the terminator.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        restart,
    imem_loader_if.slave     bus,
    output logic             cpu_run,
    output logic             load_done,
    output logic             overflow,
    output logic [ADDR_W:0]  word_count
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [31:0]     TERM_WORD = 32'h0000_0033;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    state_t            state_q,      state_d;
    logic [1:0]        byte_idx_q,   byte_idx_d;
    logic [31:0]       shift_q,      shift_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0] last_addr_q,  last_addr_d;
    logic [31:0]       last_data_q,  last_data_d;
    logic              cpu_run_q,    cpu_run_d;
    logic              overflow_q,   overflow_d;

    logic w_in_ready;
    logic w_accept;
    logic w_write;
    logic w_term;

    always_comb begin
        w_in_ready = (state_q == ST_LOAD) && !restart;
        w_accept   = bus.in_valid && w_in_ready;
        w_write    = (state_q == ST_WRITE) && !restart;
        w_term     = (shift_q == TERM_WORD);

        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        word_count_d = word_count_q;
        last_addr_d  = last_addr_q;
        last_data_d  = last_data_q;

        // restart wins over everything, including a byte or write in flight
        if (restart) begin
            state_d      = ST_LOAD;
            byte_idx_d   = 2'd0;
            shift_d      = 32'd0;
            word_count_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (w_accept) begin
                        case (byte_idx_q)
                            2'd0:    shift_d[7:0]   = bus.in_data;
                            2'd1:    shift_d[15:8]  = bus.in_data;
                            2'd2:    shift_d[23:16] = bus.in_data;
                            default: shift_d[31:24] = bus.in_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    word_count_d = word_count_q + CNT_ONE;
                    last_addr_d  = word_count_q[ADDR_W-1:0];
                    last_data_d  = shift_q;
                    if (w_term) begin
                        state_d = ST_DONE;
                    end else if (word_count_q + CNT_ONE == DEPTH_CNT) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        cpu_run_d  = (state_d == ST_DONE);
        overflow_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_LOAD;
            byte_idx_q   <= 2'd0;
            shift_q      <= 32'd0;
            word_count_q <= '0;
            last_addr_q  <= '0;
            last_data_q  <= 32'd0;
            cpu_run_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            word_count_q <= word_count_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            cpu_run_q    <= cpu_run_d;
            overflow_q   <= overflow_d;
        end
    end

    // Address/data show the live word during a write and hold the last written values otherwise
    always_comb begin
        bus.in_ready = w_in_ready;
        bus.wr_en    = w_write;
        bus.wr_addr  = w_write ? word_count_q[ADDR_W-1:0] : last_addr_q;
        bus.wr_data  = w_write ? shift_q : last_data_q;
        load_done    = w_write && w_term;
        cpu_run      = cpu_run_q;
        overflow     = overflow_q;
        word_count   = word_count_q;
    end

endmodule

`default_nettype wire
